// File: rtl/mem_bus_pkg.sv
// Shared types, defaults and helpers for the memory bus responder slice.
package mem_bus_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;
  localparam int LAT_CNT_W  = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_GRANT = 3'd1,
    RD_WAIT  = 3'd2,
    RD_DATA  = 3'd3,
    WR_GRANT = 3'd4,
    WR_HOLD  = 3'd5
  } state_t;

  // True when the full-width address falls inside the implemented words.
  function automatic logic in_range(input logic [31:0] addr, input logic [31:0] depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// Request/grant memory bus between the requester tasks and the responder.
interface mem_bus_if
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              read_request;
  logic              read_grant;
  logic              write_request;
  logic              write_grant;
  logic [ADDR_W-1:0] addr_bus;
  logic [DATA_W-1:0] wdata_bus;
  logic [DATA_W-1:0] data_bus;
  logic              data_valid;
  logic              write_done;
  logic              addr_err;
  logic              busy;

  modport master (
    output read_request, write_request, addr_bus, wdata_bus,
    input  read_grant, write_grant, data_bus, data_valid, write_done, addr_err, busy
  );

  modport slave (
    input  read_request, write_request, addr_bus, wdata_bus,
    output read_grant, write_grant, data_bus, data_valid, write_done, addr_err, busy
  );

endinterface

// File: rtl/mem_bus_responder_ram.sv
// Synchronous single-port RAM with a one-cycle registered read.
// A write also updates the read register with the new word (write-first).
module mem_sp_ram #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage and read register; contents are intentionally never cleared.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Slave side of the request/grant memory bus: arbitrates reads over writes,
// returns read data after LATENCY clocks and commits writes into a local RAM.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic   clk,
  input  logic   reset,
  mem_bus_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LATENCY - 1);

  state_t             state, state_nxt;
  logic [LAT_CNT_W-1:0] cnt, cnt_nxt;
  logic [ADDR_W-1:0]  lat_addr, lat_addr_nxt;

  logic               read_grant_q, write_grant_q, busy_q;
  logic               data_valid_q, data_valid_nxt;
  logic               write_done_q, write_done_nxt;
  logic               addr_err_q, addr_err_nxt;
  logic [DATA_W-1:0]  data_q, data_nxt;

  logic               ram_en, ram_we;
  logic [DATA_W-1:0]  ram_rdata;
  logic               req_in_range;
  logic               lat_in_range;

  assign req_in_range = in_range(32'(bus.addr_bus), 32'(DEPTH));
  assign lat_in_range = in_range(32'(lat_addr), 32'(DEPTH));

  // The RAM port is shared: it sees the live bus address in both grant states,
  // and a reset on the commit edge must suppress the write.
  mem_sp_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en & ~reset),
    .we    (ram_we & ~reset),
    .addr  (bus.addr_bus[IDX_W-1:0]),
    .wdata (bus.wdata_bus),
    .rdata (ram_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic plus the next values of every registered output.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    lat_addr_nxt   = lat_addr;
    data_nxt       = data_q;
    data_valid_nxt = 1'b0;
    write_done_nxt = 1'b0;
    addr_err_nxt   = 1'b0;
    ram_en         = 1'b0;
    ram_we         = 1'b0;

    case (state)
      IDLE: begin
        data_nxt = '0;
        if (bus.read_request)       state_nxt = RD_GRANT;
        else if (bus.write_request) state_nxt = WR_GRANT;
      end

      RD_GRANT: begin
        if (!bus.read_request) begin
          state_nxt = IDLE;
        end else begin
          lat_addr_nxt = bus.addr_bus;
          cnt_nxt      = LAT_LOAD;
          ram_en       = 1'b1;
          state_nxt    = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (!bus.read_request) begin
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          state_nxt      = RD_DATA;
          data_valid_nxt = 1'b1;
          data_nxt       = lat_in_range ? ram_rdata : '0;
          addr_err_nxt   = ~lat_in_range;
        end else begin
          cnt_nxt = cnt - LAT_CNT_W'(1);
        end
      end

      RD_DATA: begin
        if (!bus.read_request) begin
          state_nxt = IDLE;
          data_nxt  = '0;
        end else begin
          data_valid_nxt = 1'b1;
        end
      end

      WR_GRANT: begin
        ram_en         = req_in_range;
        ram_we         = req_in_range;
        write_done_nxt = req_in_range;
        addr_err_nxt   = ~req_in_range;
        state_nxt      = WR_HOLD;
      end

      WR_HOLD: begin
        if (!bus.write_request) state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output, counter and address registers; grants and busy follow the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      lat_addr      <= '0;
      read_grant_q  <= 1'b0;
      write_grant_q <= 1'b0;
      busy_q        <= 1'b0;
      data_valid_q  <= 1'b0;
      write_done_q  <= 1'b0;
      addr_err_q    <= 1'b0;
      data_q        <= '0;
    end else begin
      cnt           <= cnt_nxt;
      lat_addr      <= lat_addr_nxt;
      read_grant_q  <= (state_nxt == RD_GRANT) || (state_nxt == RD_WAIT) ||
                       (state_nxt == RD_DATA);
      write_grant_q <= (state_nxt == WR_GRANT) || (state_nxt == WR_HOLD);
      busy_q        <= (state_nxt != IDLE);
      data_valid_q  <= data_valid_nxt;
      write_done_q  <= write_done_nxt;
      addr_err_q    <= addr_err_nxt;
      data_q        <= data_nxt;
    end
  end

  assign bus.read_grant  = read_grant_q;
  assign bus.write_grant = write_grant_q;
  assign bus.busy        = busy_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.write_done  = write_done_q;
  assign bus.addr_err    = addr_err_q;
  assign bus.data_bus    = data_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder with LATENCY=2, DEPTH=1024.
module tb_mem_bus_responder;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  mem_bus_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  mem_bus_responder #(
    .ADDR_W  (16),
    .DATA_W  (32),
    .DEPTH   (1024),
    .LATENCY (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Full read from IDLE with the request held one cycle past data_valid.
  task automatic apply_read(input logic [15:0] addr, input logic [31:0] exp_data,
                            input logic exp_err, input string tag);
    bus.read_request = 1'b1;
    tick();
    check_output({tag, " rgrant"}, 32'(bus.read_grant), 32'd1);
    check_output({tag, " busy"}, 32'(bus.busy), 32'd1);
    bus.addr_bus = addr;
    tick();
    check_output({tag, " dv early1"}, 32'(bus.data_valid), 32'd0);
    tick();
    check_output({tag, " dv early2"}, 32'(bus.data_valid), 32'd0);
    tick();
    check_output({tag, " dv"}, 32'(bus.data_valid), 32'd1);
    check_output({tag, " data"}, bus.data_bus, exp_data);
    check_output({tag, " err"}, 32'(bus.addr_err), 32'(exp_err));
    tick();
    check_output({tag, " dv held"}, 32'(bus.data_valid), 32'd1);
    check_output({tag, " data held"}, bus.data_bus, exp_data);
    check_output({tag, " err pulse"}, 32'(bus.addr_err), 32'd0);
    bus.read_request = 1'b0;
    tick();
    check_output({tag, " dv drop"}, 32'(bus.data_valid), 32'd0);
    check_output({tag, " rgrant drop"}, 32'(bus.read_grant), 32'd0);
    check_output({tag, " data drop"}, bus.data_bus, 32'd0);
    check_output({tag, " busy drop"}, 32'(bus.busy), 32'd0);
  endtask

  // Full write from IDLE with the request held one cycle in WR_HOLD.
  task automatic apply_write(input logic [15:0] addr, input logic [31:0] data,
                             input logic exp_ok, input string tag);
    bus.write_request = 1'b1;
    bus.addr_bus      = addr;
    bus.wdata_bus     = data;
    tick();
    check_output({tag, " wgrant"}, 32'(bus.write_grant), 32'd1);
    check_output({tag, " no rgrant"}, 32'(bus.read_grant), 32'd0);
    tick();
    check_output({tag, " done"}, 32'(bus.write_done), 32'(exp_ok));
    check_output({tag, " err"}, 32'(bus.addr_err), 32'(!exp_ok));
    check_output({tag, " wgrant hold"}, 32'(bus.write_grant), 32'd1);
    tick();
    check_output({tag, " done pulse"}, 32'(bus.write_done), 32'd0);
    check_output({tag, " err pulse"}, 32'(bus.addr_err), 32'd0);
    check_output({tag, " wgrant hold2"}, 32'(bus.write_grant), 32'd1);
    bus.write_request = 1'b0;
    tick();
    check_output({tag, " wgrant drop"}, 32'(bus.write_grant), 32'd0);
    check_output({tag, " busy drop"}, 32'(bus.busy), 32'd0);
  endtask

  // Directed test sequence.
  initial begin
    compared          = 0;
    mismatched        = 0;
    reset             = 1'b1;
    bus.read_request  = 1'b0;
    bus.write_request = 1'b0;
    bus.addr_bus      = '0;
    bus.wdata_bus     = '0;
    tick();
    tick();
    check_output("reset rgrant", 32'(bus.read_grant), 32'd0);
    check_output("reset wgrant", 32'(bus.write_grant), 32'd0);
    check_output("reset dv", 32'(bus.data_valid), 32'd0);
    check_output("reset data", bus.data_bus, 32'd0);
    check_output("reset busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] preload and basic read");
    apply_write(16'h0010, 32'hDEADBEEF, 1'b1, "wr10");
    apply_read(16'h0010, 32'hDEADBEEF, 1'b0, "rd10");

    $display("[TB] write then read top word");
    apply_write(16'h03FF, 32'h12345678, 1'b1, "wr3ff");
    apply_read(16'h03FF, 32'h12345678, 1'b0, "rd3ff");

    $display("[TB] out of range");
    apply_read(16'h0400, 32'h0, 1'b1, "rd400");
    apply_write(16'hFFFF, 32'hA5A5A5A5, 1'b0, "wrffff");
    apply_read(16'h03FF, 32'h12345678, 1'b0, "rd3ff after oob");

    $display("[TB] simultaneous requests");
    bus.read_request  = 1'b1;
    bus.write_request = 1'b1;
    bus.addr_bus      = 16'h0010;
    bus.wdata_bus     = 32'hCAFEF00D;
    tick();
    check_output("sim rgrant", 32'(bus.read_grant), 32'd1);
    check_output("sim no wgrant", 32'(bus.write_grant), 32'd0);
    tick();
    tick();
    tick();
    check_output("sim dv", 32'(bus.data_valid), 32'd1);
    check_output("sim data", bus.data_bus, 32'hDEADBEEF);
    check_output("sim wgrant wait", 32'(bus.write_grant), 32'd0);
    bus.read_request = 1'b0;
    bus.addr_bus     = 16'h0020;
    tick();
    check_output("sim idle rgrant", 32'(bus.read_grant), 32'd0);
    check_output("sim idle wgrant", 32'(bus.write_grant), 32'd0);
    tick();
    check_output("sim wgrant", 32'(bus.write_grant), 32'd1);
    tick();
    check_output("sim wdone", 32'(bus.write_done), 32'd1);
    bus.write_request = 1'b0;
    tick();
    check_output("sim wgrant drop", 32'(bus.write_grant), 32'd0);
    apply_read(16'h0020, 32'hCAFEF00D, 1'b0, "rd20");

    $display("[TB] abort read");
    bus.read_request = 1'b1;
    tick();
    bus.addr_bus = 16'h0010;
    tick();
    bus.read_request = 1'b0;
    tick();
    check_output("abort rgrant", 32'(bus.read_grant), 32'd0);
    check_output("abort busy", 32'(bus.busy), 32'd0);
    check_output("abort dv", 32'(bus.data_valid), 32'd0);
    tick();
    check_output("abort dv later", 32'(bus.data_valid), 32'd0);

    $display("[TB] reset mid read");
    bus.read_request = 1'b1;
    tick();
    bus.addr_bus = 16'h0010;
    tick();
    tick();
    tick();
    check_output("rst dv before", 32'(bus.data_valid), 32'd1);
    reset = 1'b1;
    tick();
    check_output("rst dv", 32'(bus.data_valid), 32'd0);
    check_output("rst rgrant", 32'(bus.read_grant), 32'd0);
    check_output("rst data", bus.data_bus, 32'd0);
    check_output("rst busy", 32'(bus.busy), 32'd0);
    reset            = 1'b0;
    bus.read_request = 1'b0;
    tick();
    apply_read(16'h0010, 32'hDEADBEEF, 1'b0, "rd after rst");

    $display("[TB] reset on write commit edge");
    bus.write_request = 1'b1;
    bus.addr_bus      = 16'h0010;
    bus.wdata_bus     = 32'h0BADBAD0;
    tick();
    check_output("rstwr wgrant", 32'(bus.write_grant), 32'd1);
    reset = 1'b1;
    tick();
    check_output("rstwr wdone", 32'(bus.write_done), 32'd0);
    check_output("rstwr wgrant", 32'(bus.write_grant), 32'd0);
    reset             = 1'b0;
    bus.write_request = 1'b0;
    tick();
    apply_read(16'h0010, 32'hDEADBEEF, 1'b0, "rd no commit");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
